// File: rtl/hazard_controller_pkg.sv
// hazard_controller_pkg: shared FSM state type and timeout default for the hazard controller
package hazard_controller_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, MULTI_WAIT} hz_state_e;
  localparam int MULTI_TIMEOUT_DEF = 64;
endpackage

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: pipeline-side hazard inputs and stall/flush/status outputs
interface hazard_controller_if #(parameter int CNT_W = 32);
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic id_uses_rs1, id_uses_rs2, id_ex_mem_read, id_ex_is_multi;
  logic multi_done, ex_branch_taken, dmem_req, dmem_ready;
  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic multi_start, multi_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  modport master (
    output id_rs1, id_rs2, id_ex_rd, id_uses_rs1, id_uses_rs2, id_ex_mem_read, id_ex_is_multi,
    output multi_done, ex_branch_taken, dmem_req, dmem_ready,
    input pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    input if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
    input multi_start, multi_timeout, stall_cycles, flush_events
  );
  modport slave (
    input id_rs1, id_rs2, id_ex_rd, id_uses_rs1, id_uses_rs2, id_ex_mem_read, id_ex_is_multi,
    input multi_done, ex_branch_taken, dmem_req, dmem_ready,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
    output multi_start, multi_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_controller_match.sv
// hazard_match: load-use comparator; a load to x0 never matches
module hazard_match (
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       uses_rs1,
  input  logic       uses_rs2,
  input  logic       mem_read,
  output logic       hit
);
  assign hit = mem_read && |rd && ((uses_rs1 && rd == rs1) || (uses_rs2 && rd == rs2));
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/flush control with memory wait, multi-cycle wait and load-use handling
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int MULTI_TIMEOUT = MULTI_TIMEOUT_DEF
) (
  input logic clk,
  input logic rst,
  hazard_controller_if.slave hz
);
  localparam int TW = $clog2(MULTI_TIMEOUT + 1);
  hz_state_e state, state_n;
  logic [TW-1:0] tcnt;
  logic lu, mem_wait, in_run, in_mem, in_multi;
  logic run_mem, run_multi, run_br, run_lu, mem_hold, mw_hold, to_c, all_stall, mw_mem;
  hazard_match u_match (
    .rd(hz.id_ex_rd), .rs1(hz.id_rs1), .rs2(hz.id_rs2),
    .uses_rs1(hz.id_uses_rs1), .uses_rs2(hz.id_uses_rs2),
    .mem_read(hz.id_ex_mem_read), .hit(lu)
  );
  always_comb begin
    mem_wait  = hz.dmem_req && !hz.dmem_ready;
    in_run    = state == RUN;
    in_mem    = state == MEM_WAIT;
    in_multi  = state == MULTI_WAIT;
    run_mem   = in_run && mem_wait;
    run_multi = in_run && !mem_wait && hz.id_ex_is_multi;
    run_br    = in_run && !mem_wait && !hz.id_ex_is_multi && hz.ex_branch_taken;
    run_lu    = in_run && !mem_wait && !hz.id_ex_is_multi && !hz.ex_branch_taken && lu;
    mem_hold  = in_mem && !hz.dmem_ready;
    to_c      = in_multi && !hz.multi_done && tcnt == TW'(MULTI_TIMEOUT);
    mw_hold   = in_multi && !hz.multi_done && !to_c;
    mw_mem    = mw_hold && mem_wait;
    all_stall = run_mem || mem_hold;
    hz.pc_stall     = all_stall || run_multi || run_lu || mw_hold;
    hz.if_id_stall  = all_stall || run_multi || run_lu || mw_hold;
    hz.id_ex_stall  = all_stall || run_multi || mw_hold;
    hz.ex_mem_stall = all_stall || mw_mem;
    hz.if_id_flush  = run_br;
    hz.id_ex_flush  = run_br || run_lu || to_c;
    hz.ex_mem_flush = run_multi || mw_hold;
    hz.mem_wb_flush = all_stall || mw_mem;
    hz.multi_start  = run_multi && !rst;
    state_n = run_mem ? MEM_WAIT :
              run_multi ? MULTI_WAIT :
              ((in_mem && hz.dmem_ready) || (in_multi && !mw_hold)) ? RUN : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= RUN;
      tcnt             <= '0;
      hz.multi_timeout <= 1'b0;
      hz.stall_cycles  <= '0;
      hz.flush_events  <= '0;
    end else begin
      state <= state_n;
      tcnt  <= run_multi ? '0 : mw_hold ? tcnt + TW'(1) : tcnt;
      if (to_c) hz.multi_timeout <= 1'b1;
      hz.stall_cycles <= hz.stall_cycles + CNT_W'(hz.pc_stall && !(&hz.stall_cycles));
      hz.flush_events <= hz.flush_events + CNT_W'(hz.if_id_flush && !(&hz.flush_events));
    end
  end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed scenarios plus randomized traffic against a behavioural model
module tb_hazard_controller;
  localparam int CW = 4;
  localparam int TO = 8;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst;
  int checks = 0, errors = 0;
  int mode = 0, wcnt = 0, m_stall = 0, m_flush = 0;
  bit m_to = 1'b0;
  int n_ps = 0, n_ms = 0;
  always #5 clk = ~clk;
  hazard_controller_if #(.CNT_W(CW)) hz ();
  hazard_controller #(.CNT_W(CW), .MULTI_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .hz(hz));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_ex_rd = 0;
    hz.id_uses_rs1 = 0; hz.id_uses_rs2 = 0; hz.id_ex_mem_read = 0; hz.id_ex_is_multi = 0;
    hz.multi_done = 0; hz.ex_branch_taken = 0; hz.dmem_req = 0; hz.dmem_ready = 0;
  endtask

  task automatic load_use(input logic [4:0] r);
    hz.id_ex_mem_read = 1; hz.id_ex_rd = r; hz.id_rs1 = r; hz.id_uses_rs1 = 1;
  endtask

  // bit order: pc, if_id, id_ex, ex_mem stalls; if_id, id_ex, ex_mem, mem_wb flushes; multi_start
  task automatic step();
    logic mw, lu;
    logic [8:0] e;
    int nmode, nw;
    bit nto;
    @(negedge clk);
    mw = hz.dmem_req && !hz.dmem_ready;
    lu = hz.id_ex_mem_read && hz.id_ex_rd != 0 &&
         ((hz.id_uses_rs1 && hz.id_ex_rd == hz.id_rs1) || (hz.id_uses_rs2 && hz.id_ex_rd == hz.id_rs2));
    e = '0; nmode = mode; nw = wcnt; nto = m_to;
    if (mode == 0) begin
      if (mw) begin e = 9'b111100010; nmode = 1; end
      else if (hz.id_ex_is_multi) begin e = 9'b111000100; e[0] = !rst; nmode = 2; nw = 0; end
      else if (hz.ex_branch_taken) e = 9'b000011000;
      else if (lu) e = 9'b110001000;
    end else if (mode == 1) begin
      if (!hz.dmem_ready) e = 9'b111100010;
      else nmode = 0;
    end else begin
      if (hz.multi_done) nmode = 0;
      else if (wcnt == TO) begin e = 9'b000001000; nto = 1; nmode = 0; end
      else begin
        e = 9'b111000100 | (mw ? 9'b000100010 : 9'b0);
        nw = wcnt + 1;
      end
    end
    check("outs", 32'({hz.pc_stall, hz.if_id_stall, hz.id_ex_stall, hz.ex_mem_stall,
                       hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush, hz.mem_wb_flush,
                       hz.multi_start}), 32'(e));
    n_ps += int'(hz.pc_stall);
    n_ms += int'(hz.multi_start);
    @(posedge clk);
    if (rst) begin
      mode = 0; wcnt = 0; m_to = 0; m_stall = 0; m_flush = 0;
    end else begin
      mode = nmode; wcnt = nw; m_to = nto;
      if (e[8] && m_stall < CMAX) m_stall++;
      if (e[4] && m_flush < CMAX) m_flush++;
    end
    #1;
    check("stall_cycles", 32'(hz.stall_cycles), 32'(m_stall));
    check("flush_events", 32'(hz.flush_events), 32'(m_flush));
    check("multi_timeout", 32'(hz.multi_timeout), 32'(m_to));
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    step(); rst = 0;
    step();
    load_use(5); step(); idle(); step();
    check("lu_stall_cycles", 32'(hz.stall_cycles), 1);
    n_ps = 0; load_use(0); step(); idle(); step();
    check("x0_no_stall", 32'(n_ps), 0);
    do_reset();
    n_ps = 0; load_use(5); hz.ex_branch_taken = 1; step(); idle(); step();
    check("br_lu_flush_events", 32'(hz.flush_events), 1);
    check("br_lu_no_stall", 32'(n_ps), 0);
    n_ps = 0; n_ms = 0;
    hz.id_ex_is_multi = 1; hz.ex_branch_taken = 1; step(); idle();
    repeat (3) step();
    hz.multi_done = 1; step(); idle(); step();
    check("multi_stall_len", 32'(n_ps), 4);
    check("multi_start_pulses", 32'(n_ms), 1);
    n_ps = 0; hz.dmem_req = 1;
    repeat (3) step();
    hz.dmem_ready = 1; step(); idle(); step();
    check("mem_stall_len", 32'(n_ps), 3);
    hz.id_ex_is_multi = 1; step(); idle();
    repeat (TO + 1) step();
    step();
    check("timeout_set", 32'(hz.multi_timeout), 1);
    do_reset();
    check("timeout_cleared", 32'(hz.multi_timeout), 0);
    hz.id_ex_is_multi = 1; step(); rst = 1; step(); rst = 0; idle(); step();
    for (int i = 0; i < 3000; i++) begin
      hz.id_rs1 = 5'($urandom_range(0, 3)); hz.id_rs2 = 5'($urandom_range(0, 3));
      hz.id_ex_rd = 5'($urandom_range(0, 3));
      hz.id_uses_rs1 = 1'($urandom); hz.id_uses_rs2 = 1'($urandom);
      hz.id_ex_mem_read = 1'($urandom); hz.id_ex_is_multi = ($urandom % 8) == 0;
      hz.multi_done = ($urandom % 6) == 0; hz.ex_branch_taken = ($urandom % 4) == 0;
      hz.dmem_req = ($urandom % 3) == 0; hz.dmem_ready = 1'($urandom);
      rst = ($urandom % 64) == 0;
      step();
    end
    rst = 0;
    do_reset();
    load_use(3);
    repeat (20) step();
    check("stall_saturate", 32'(hz.stall_cycles), CMAX);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
